ifetch_unit: RTL and testbench

//  Decoupled instruction-fetch front end: owns the fetch PC, drives the synchronous imem,

---
 rtl/ifetch_unit_pkg.sv | 18 +
 rtl/ifetch_queue.sv | 53 +++++
 rtl/ifetch_unit.sv | 79 +++++++
 tb/tb_ifetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC, word alignment,
// the NOP encoding and the {ir,pc} queue entry layout.
package ifetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small power-of-two FIFO of fetched {ir,pc} entries with synchronous flush.
// The head is read straight from registered storage; there is no write-through path.
module ifetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // NOTE: storage is cleared on reset so the head reads as zero before the first push;
  // this costs a reset on every entry, which is acceptable at this depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Decoupled fetch front end: owns the fetch PC, issues one imem read per cycle while
// queue credit allows, and presents the queue head to decode on a valid/ready handshake.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          push;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign pop = id_valid & id_ready;

  // Slots already claimed after this cycle's pop; a new request needs one free slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  assign imem_req  = rst & (redirect | (occupancy < (CW+1)'(DEPTH)));
  assign imem_addr = redirect ? word_align(redirect_pc) : fetch_pc;

  // A redirect kills the word returning this cycle, since it belongs to the old stream.
  assign push      = inflight & ~redirect;
  assign push_data = '{ir: imem_rdata, pc: req_pc};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= imem_addr + 32'd4;
        req_pc   <= imem_addr;
      end
    end
  end

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop & ~redirect),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign id_valid = (count != '0);
  assign id_ir    = id_valid ? head.ir : NOP;
  assign id_pc    = id_valid ? head.pc : '0;
  assign id_pc4   = id_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: randomized and directed traffic compared each
// cycle against a queue-based reference model of the fetch front end.
module tb_ifetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ir       (id_ir),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected queue contents as a list of PCs, plus fetch state.
  logic [31:0] mq[$];
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fetch_pc;

  logic        prev_req;
  logic [31:0] prev_addr;
  int          cyc;
  int          first_valid_cyc;
  logic        have_acc;
  logic [31:0] first_acc;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl          = 1'b0;
    m_infl_pc       = 32'h0;
    m_fetch_pc      = 32'h0;
    prev_req        = 1'b0;
    prev_addr       = 32'h0;
    cyc             = 0;
    first_valid_cyc = -1;
    have_acc        = 1'b0;
    first_acc       = 32'hDEAD_BEEF;
  endtask

  task automatic mark();
    have_acc  = 1'b0;
    first_acc = 32'hDEAD_BEEF;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        m_valid;
    logic        m_pop;
    logic        e_req;
    logic [31:0] e_addr;
    int          occ;
    @(negedge clk);
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = rdy;
    imem_rdata  = prev_req ? imem_word(prev_addr) : $urandom();
    #1;
    m_valid = (mq.size() != 0);
    m_pop   = m_valid && rdy;
    occ     = mq.size() + int'(m_infl) - int'(m_pop);
    e_req   = rd || (occ < DEPTH);
    e_addr  = rd ? (rpc & 32'hFFFF_FFFC) : m_fetch_pc;
    check("imem_req", 32'(imem_req), 32'(e_req));
    check("imem_addr", imem_addr, e_addr);
    check("id_valid", 32'(id_valid), 32'(m_valid));
    if (m_valid) begin
      check("id_pc", id_pc, mq[0]);
      check("id_ir", id_ir, imem_word(mq[0]));
      check("id_pc4", id_pc4, mq[0] + 32'd4);
    end
    if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (id_valid && rdy && !rd && !have_acc) begin
      have_acc  = 1'b1;
      first_acc = id_pc;
    end
    if (rd) mq.delete();
    else begin
      if (m_pop) mq.delete(0);
      if (m_infl) mq.push_back(m_infl_pc);
    end
    m_infl    = e_req;
    m_infl_pc = e_addr;
    if (e_req) m_fetch_pc = e_addr + 32'd4;
    prev_req  = imem_req;
    prev_addr = imem_addr;
    cyc++;
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    imem_rdata  = 32'h0;
    model_reset();

    // Reset state
    #12;
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_ir", id_ir, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc4", id_pc4, 32'h0);

    // Release mid-cycle so the next edge is edge 0
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();

    // Streaming with decode always ready
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    check("first_valid_cycle", 32'(first_valid_cyc), 32'd2);

    // Stall then release
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect to unaligned target while stalled
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    mark();
    step(1'b1, 32'h43, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    check("redir_0x43_first", first_acc, 32'h40);

    // Redirect coincident with a handshake
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    mark();
    step(1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check("redir_handshake_first", first_acc, 32'h300);

    // Back-to-back redirects
    mark();
    step(1'b1, 32'h100, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check("redir_b2b_first", first_acc, 32'h200);

    // Address wrap
    mark();
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    check("redir_wrap_first", first_acc, 32'hFFFF_FFF8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      rd  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom();
      rdy = ((i / 40) % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      step(rd, rpc, rdy);
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    redirect = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_imem_req", 32'(imem_req), 32'h0);
    check("async_rst_id_valid", 32'(id_valid), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    check("rerst_first_valid_cycle", 32'(first_valid_cyc), 32'd2);
    check("rerst_first_pc", first_acc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
